grain_128a_par: RTL

- W-bit-per-clock parallel successor to the bit-serial Grain-128a keystream generator in the crypto library.
- Loads a 128-bit key and 96-bit IV, then runs the 256-step warm-up in 256/W cycles with the pre-output fed back.
- Delivers W keystream bits per accepted transfer over a valid/ready handshake with back-pressure and a transfer counter.
- Sits between the key-management front end and the XOR data path.

---
 rtl/grain_128a_par.sv | 128 ++++++++++++
 1 files changed

// File: rtl/grain_128a_par.sv
// rtl/grain_128a_par.sv - Grain-128a keystream generator, W bits per clock.
// Key/IV load, 256-step warm-up with pre-output feedback, valid/ready keystream words.
module grain_128a_par #(
  parameter int W            = 1,
  parameter int WARMUP_STEPS = 256,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_req,
  input  logic [127:0]     key,
  input  logic [95:0]      iv,
  output logic             busy,
  output logic             ready,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [W-1:0]     ks_data,
  output logic [CNT_W-1:0] ks_count
);
  localparam int WCLKS = WARMUP_STEPS / W;
  localparam int PH_W  = (WCLKS > 1) ? $clog2(WCLKS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WCLKS - 1);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32)) begin : g_bad_w
    $error("grain_128a_par: W must be 1, 2, 4, 8, 16 or 32");
  end
  if (WARMUP_STEPS % W != 0) begin : g_bad_warmup
    $error("grain_128a_par: WARMUP_STEPS must be a multiple of W");
  end

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [127:0]     r_s;
  logic [127:0]     r_b;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [127:0]     w_s_nxt;
  logic [127:0]     w_b_nxt;
  logic [W-1:0]     w_y;
  logic             w_step;
  logic             w_xfer;

  // W cipher steps chained within one clock; y is fed back only during warm-up.
  always_comb begin : p_unroll
    logic [127:0] s;
    logic [127:0] b;
    logic         f;
    logic         g;
    logic         h;
    logic         y;
    s   = r_s;
    b   = r_b;
    f   = 1'b0;
    g   = 1'b0;
    h   = 1'b0;
    y   = 1'b0;
    w_y = '0;
    for (int k = 0; k < W; k++) begin
      f = s[0] ^ s[7] ^ s[38] ^ s[70] ^ s[81] ^ s[96];
      g = s[0] ^ b[0] ^ b[26] ^ b[56] ^ b[91] ^ b[96]
        ^ (b[3] & b[67]) ^ (b[11] & b[13]) ^ (b[17] & b[18]) ^ (b[27] & b[59])
        ^ (b[40] & b[48]) ^ (b[61] & b[65]) ^ (b[68] & b[84])
        ^ (b[22] & b[24] & b[25]) ^ (b[70] & b[78] & b[82])
        ^ (b[88] & b[92] & b[93] & b[95]);
      h = (b[12] & s[8]) ^ (s[13] & s[20]) ^ (b[95] & s[42]) ^ (s[60] & s[79])
        ^ (b[12] & b[95] & s[94]);
      y = h ^ s[93] ^ b[2] ^ b[15] ^ b[36] ^ b[45] ^ b[64] ^ b[73] ^ b[89];
      w_y[k] = y;
      if (r_state == WARMUP) begin
        f = f ^ y;
        g = g ^ y;
      end
      s = {f, s[127:1]};
      b = {g, b[127:1]};
    end
    w_s_nxt = s;
    w_b_nxt = b;
  end

  assign ks_valid = (r_state == RUN) && !init_req;
  assign w_xfer   = ks_valid && ks_ready;
  assign busy     = (r_state == WARMUP);
  assign ready    = (r_state == RUN);
  assign ks_data  = (r_state == RUN) ? w_y : '0;
  assign ks_count = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    case (r_state)
      WARMUP: begin
        w_step = 1'b1;
        if (r_phase == PH_LAST) w_state_nxt = RUN;
      end
      RUN:     w_step = w_xfer;
      default: ;
    endcase
    if (init_req) w_state_nxt = WARMUP;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s     <= '0;
      r_b     <= '0;
      r_phase <= '0;
      r_cnt   <= '0;
    end else if (init_req) begin
      r_s     <= {1'b0, {31{1'b1}}, iv};
      r_b     <= key;
      r_phase <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_step) begin
        r_s <= w_s_nxt;
        r_b <= w_b_nxt;
      end
      if (r_state == WARMUP) r_phase <= r_phase + PH_W'(1);
      if (w_xfer && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule
